// File: rtl/ptp_ctrl_v2.sv
// ---------------------------------------------------------------------------
// ptp_ctrl_v2 -- PTP session controller for one TSN switch port.
//
// Master role: answers every received Delay_Req with a Delay_Resp request.
// Slave role : waits for Sync, requests a Delay_Req, confirms it left the
//              port, then waits for the Delay_Resp. Each slave phase has a
//              timeout with a bounded number of retries.
// Sits between rx_proc/tx_proc and cyc_sync.
//
// Ports
//   clk, reset                         clock, async active-low reset
//   ptp_recv_type_valid/ptp_recv_type  received PTP type strobe (rx_proc)
//   ptp_send_type_valid/ptp_send_type  transmitted PTP type strobe (tx_proc)
//   sync_start                         session enable (level)
//   auto_mode                          slave re-arms after a good exchange
//   device_role                        bit0: 1 master, 0 slave; bit1 unused
//   clear_cnt                          synchronous statistics clear
//   send_dreq_pkt / send_dresp_pkt     1-cycle transmit requests to tx_proc
//   m_or_s                             device_role[0]
//   status_ok / error / timeout_err    session status levels
//   retry_cnt                          timeouts retried in this session
//   dreq_cnt / dresp_cnt               saturating request counters
// ---------------------------------------------------------------------------
module ptp_ctrl_v2 #(
    parameter int TYPE_W      = 4,
    parameter int T_SYNC      = 1,
    parameter int T_DREQ      = 3,
    parameter int T_DRESP     = 4,
    parameter int CNT_W       = 32,
    parameter int TO_W        = 20,
    parameter int TIMEOUT_CYC = 1000000,
    parameter int MAX_RETRY   = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ptp_recv_type_valid,
    input  logic [TYPE_W-1:0] ptp_recv_type,
    input  logic              ptp_send_type_valid,
    input  logic [TYPE_W-1:0] ptp_send_type,
    input  logic              sync_start,
    input  logic              auto_mode,
    input  logic [1:0]        device_role,
    input  logic              clear_cnt,
    output logic              send_dreq_pkt,
    output logic              send_dresp_pkt,
    output logic              m_or_s,
    output logic              status_ok,
    output logic              error,
    output logic              timeout_err,
    output logic [3:0]        retry_cnt,
    output logic [CNT_W-1:0]  dreq_cnt,
    output logic [CNT_W-1:0]  dresp_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MASTER_RUN,
        S_WAIT_SYNC,
        S_WAIT_DREQ_TX,
        S_WAIT_DRESP_RX
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [TO_W-1:0]    r_timer;
    logic [3:0]         r_retry_cnt;
    logic               r_status_ok;
    logic               r_error;
    logic               r_timeout_err;
    logic               r_dreq_pulse;
    logic               r_dresp_pulse;
    logic [CNT_W-1:0]   r_dreq_cnt;
    logic [CNT_W-1:0]   r_dresp_cnt;

    // Decoded strobes and slave-side conditions shared by both comb processes.
    logic w_recv_sync, w_recv_dreq, w_recv_dresp, w_send_dreq;
    logic w_is_slave, w_abort, w_to_fire, w_can_retry;
    logic w_unused;

    assign w_recv_sync  = ptp_recv_type_valid && (ptp_recv_type == TYPE_W'(T_SYNC));
    assign w_recv_dreq  = ptp_recv_type_valid && (ptp_recv_type == TYPE_W'(T_DREQ));
    assign w_recv_dresp = ptp_recv_type_valid && (ptp_recv_type == TYPE_W'(T_DRESP));
    assign w_send_dreq  = ptp_send_type_valid && (ptp_send_type == TYPE_W'(T_DREQ));

    assign w_is_slave  = (r_state == S_WAIT_SYNC) || (r_state == S_WAIT_DREQ_TX) ||
                         (r_state == S_WAIT_DRESP_RX);
    // Dropping the enable wins over everything else in a slave phase; the
    // timeout in turn wins over any strobe arriving in the same cycle.
    assign w_abort     = w_is_slave && !sync_start;
    assign w_to_fire   = w_is_slave && sync_start && (r_timer == TO_W'(TIMEOUT_CYC - 1));
    assign w_can_retry = r_retry_cnt < 4'(MAX_RETRY);

    assign w_unused = device_role[1];

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of block order.
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state logic.
    always_comb begin
        // NOTE: default first so no path leaves the signal unassigned (latch).
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (sync_start)
                    w_state_nxt = device_role[0] ? S_MASTER_RUN : S_WAIT_SYNC;
            end
            S_MASTER_RUN: begin
                if (!sync_start || !device_role[0]) w_state_nxt = S_IDLE;
            end
            default: begin
                if (w_abort) begin
                    w_state_nxt = S_IDLE;
                end else if (w_to_fire) begin
                    w_state_nxt = w_can_retry ? S_WAIT_SYNC : S_IDLE;
                end else begin
                    case (r_state)
                        S_WAIT_SYNC:
                            if (w_recv_sync) w_state_nxt = S_WAIT_DREQ_TX;
                        S_WAIT_DREQ_TX:
                            if (ptp_send_type_valid)
                                w_state_nxt = w_send_dreq ? S_WAIT_DRESP_RX : S_IDLE;
                        S_WAIT_DRESP_RX:
                            if (w_recv_dresp)
                                w_state_nxt = (auto_mode && sync_start) ? S_WAIT_SYNC : S_IDLE;
                            else if (w_recv_sync)
                                w_state_nxt = S_WAIT_DREQ_TX;
                            else if (ptp_recv_type_valid)
                                w_state_nxt = S_IDLE;
                        default: w_state_nxt = S_IDLE;
                    endcase
                end
            end
        endcase
    end

    // Output / status next values.
    logic       w_dreq_fire, w_dresp_fire;
    logic       w_status_ok_nxt, w_error_nxt, w_timeout_err_nxt;
    logic [3:0] w_retry_nxt;

    always_comb begin
        w_dreq_fire       = 1'b0;
        w_dresp_fire      = 1'b0;
        w_status_ok_nxt   = r_status_ok;
        w_error_nxt       = r_error;
        w_timeout_err_nxt = r_timeout_err;
        w_retry_nxt       = r_retry_cnt;
        case (r_state)
            S_IDLE: begin
                if (sync_start) begin
                    w_status_ok_nxt   = 1'b0;
                    w_error_nxt       = 1'b0;
                    w_timeout_err_nxt = 1'b0;
                    w_retry_nxt       = 4'd0;
                end
            end
            S_MASTER_RUN: begin
                if (sync_start && device_role[0] && w_recv_dreq) w_dresp_fire = 1'b1;
            end
            default: begin
                if (w_abort) begin
                    // Leave quietly; status is held.
                end else if (w_to_fire) begin
                    if (w_can_retry) begin
                        w_retry_nxt = r_retry_cnt + 4'd1;
                    end else begin
                        w_error_nxt       = 1'b1;
                        w_timeout_err_nxt = 1'b1;
                    end
                end else begin
                    case (r_state)
                        S_WAIT_SYNC: begin
                            if (w_recv_sync) begin
                                w_dreq_fire = 1'b1;
                                if (auto_mode) w_status_ok_nxt = 1'b0;
                            end
                        end
                        S_WAIT_DREQ_TX: begin
                            if (ptp_send_type_valid && !w_send_dreq) w_error_nxt = 1'b1;
                        end
                        S_WAIT_DRESP_RX: begin
                            if (w_recv_dresp) begin
                                w_status_ok_nxt = 1'b1;
                            end else if (w_recv_sync) begin
                                w_dreq_fire = 1'b1;
                                if (auto_mode) w_status_ok_nxt = 1'b0;
                            end else if (ptp_recv_type_valid) begin
                                w_error_nxt = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        endcase
    end

    // Registered outputs and phase timer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_dreq_pulse  <= 1'b0;
            r_dresp_pulse <= 1'b0;
            r_status_ok   <= 1'b0;
            r_error       <= 1'b0;
            r_timeout_err <= 1'b0;
            r_retry_cnt   <= 4'd0;
            r_timer       <= '0;
        end else begin
            r_dreq_pulse  <= w_dreq_fire;
            r_dresp_pulse <= w_dresp_fire;
            r_status_ok   <= w_status_ok_nxt;
            r_error       <= w_error_nxt;
            r_timeout_err <= w_timeout_err_nxt;
            r_retry_cnt   <= w_retry_nxt;
            // A retry re-enters WAIT_SYNC from WAIT_SYNC, so it restarts the
            // timer explicitly rather than relying on a state change.
            if (!w_is_slave || (w_state_nxt != r_state) || w_to_fire)
                r_timer <= '0;
            else
                r_timer <= r_timer + 1'b1;
        end
    end

    // Saturating statistics; clear wins over a same-cycle increment.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_dreq_cnt  <= '0;
            r_dresp_cnt <= '0;
        end else if (clear_cnt) begin
            r_dreq_cnt  <= '0;
            r_dresp_cnt <= '0;
        end else begin
            if (r_dreq_pulse && (r_dreq_cnt != '1))   r_dreq_cnt  <= r_dreq_cnt + 1'b1;
            if (r_dresp_pulse && (r_dresp_cnt != '1)) r_dresp_cnt <= r_dresp_cnt + 1'b1;
        end
    end

    assign send_dreq_pkt  = r_dreq_pulse;
    assign send_dresp_pkt = r_dresp_pulse;
    assign m_or_s         = device_role[0];
    assign status_ok      = r_status_ok;
    assign error          = r_error;
    assign timeout_err    = r_timeout_err;
    assign retry_cnt      = r_retry_cnt;
    assign dreq_cnt       = r_dreq_cnt;
    assign dresp_cnt      = r_dresp_cnt;

endmodule
